// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD display path: FSM states,
// BCD digit width and the minimum digit count needed for a given binary width.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Number of decimal digits needed to print 2^width - 1.
    function automatic int min_digits(input int width);
        longint unsigned v;
        int d;
        v = (64'd1 << width) - 64'd1;
        d = 0;
        do begin
            v = v / 64'd10;
            d++;
        end while (v != 64'd0);
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Ports: digit (4-bit BCD in), adj (4-bit corrected digit out).
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative (one bit per clock) binary-to-BCD converter with sign flag and
// leading-zero mask for the seven-segment display path.
// Ports: i_clk, i_reset (sync, active-high), i_start/i_signed/i_value request,
//        o_busy, o_done pulse, o_bcd (digit 0 in [3:0]), o_neg, o_nz_mask.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic                            i_signed,
    input  logic [WIDTH-1:0]                i_value,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   o_bcd,
    output logic                            o_neg,
    output logic [DIGITS-1:0]               o_nz_mask
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH out of range");
    end

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               sign;
    logic [WIDTH-1:0]   mag;
    logic [DIGITS-1:0]  mask;
    logic               nz_seen;

    // Negation is done in WIDTH bits, so the most negative value maps to
    // 2^(WIDTH-1) as an unsigned magnitude.
    assign sign   = i_signed & i_value[WIDTH-1];
    assign mag    = sign ? -i_value : i_value;
    assign o_busy = (state != IDLE);

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj   (acc_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // A digit is shown if it or any more significant digit is nonzero;
    // the units digit is always shown.
    always_comb begin
        mask    = '0;
        nz_seen = 1'b0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            nz_seen = nz_seen | (|acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
            mask[d] = nz_seen;
        end
        mask[0] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc       <= '0;
            shreg     <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            o_done    <= 1'b0;
            o_bcd     <= '0;
            o_neg     <= 1'b0;
            o_nz_mask <= DIGITS'(1);
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        shreg <= mag;
                        neg   <= sign;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    {acc, shreg} <= {acc_adj[ACC_W-2:0], shreg, 1'b0};
                    cnt          <= cnt - CNT_W'(1);
                end
                DONE: begin
                    o_bcd     <= acc;
                    o_neg     <= neg;
                    o_nz_mask <= mask;
                    o_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model compared
// every cycle, plus directed cases with hand-computed results.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic        neg;
    logic [9:0]  mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_signed  (sgn),
        .i_value   (value),
        .o_busy    (busy),
        .o_done    (done),
        .o_bcd     (bcd),
        .o_neg     (neg),
        .o_nz_mask (mask)
    );

    // Reference: decimal digits by repeated division, mask by magnitude
    // comparison against powers of ten.
    function automatic void ref_conv(input bit s, input logic [31:0] v,
                                     output bit n, output logic [39:0] b,
                                     output logic [9:0] m);
        longint unsigned mg;
        longint unsigned t;
        longint unsigned p;
        n  = s && v[31];
        mg = n ? (64'd1 << 32) - {32'd0, v} : {32'd0, v};
        t  = mg;
        b  = '0;
        for (int d = 0; d < 10; d++) begin
            b[d*4 +: 4] = 4'(t % 64'd10);
            t = t / 64'd10;
        end
        p = 64'd1;
        m = '0;
        for (int d = 0; d < 10; d++) begin
            m[d] = (d == 0) || (mg >= p);
            p = p * 64'd10;
        end
    endfunction

    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_neg  = 1'b0;
    logic [39:0] m_bcd  = '0;
    logic [9:0]  m_mask = 10'd1;
    bit          p_neg;
    logic [39:0] p_bcd;
    logic [9:0]  p_mask;
    longint      edge_n  = 0;
    longint      done_at = -1;
    bit          armed   = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_bcd  = '0;
            m_neg  = 1'b0;
            m_mask = 10'd1;
        end else begin
            m_done = 1'b0;
            if (m_busy && edge_n == done_at) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_bcd  = p_bcd;
                m_neg  = p_neg;
                m_mask = p_mask;
            end else if (!m_busy && start) begin
                m_busy  = 1'b1;
                done_at = edge_n + WIDTH + 1;
                ref_conv(sgn, value, p_neg, p_bcd, p_mask);
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (busy !== m_busy || done !== m_done || bcd !== m_bcd ||
                neg !== m_neg || mask !== m_mask) begin
                failures++;
                $display("FAIL cycle_cmp edge=%0d got busy=%b done=%b bcd=%h neg=%b mask=%b expected busy=%b done=%b bcd=%h neg=%b mask=%b",
                         edge_n, busy, done, bcd, neg, mask,
                         m_busy, m_done, m_bcd, m_neg, m_mask);
            end
        end
    end

    task automatic check_lit(input string name, input logic [39:0] eb,
                             input bit en, input logic [9:0] em);
        checks++;
        if (bcd !== eb || neg !== en || mask !== em) begin
            failures++;
            $display("FAIL %s got bcd=%h neg=%b mask=%b expected bcd=%h neg=%b mask=%b",
                     name, bcd, neg, mask, eb, en, em);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Starts a conversion at a negedge (count 0), then counts negedges until
    // o_done is seen and how many of those had o_busy high.
    task automatic conv(input bit s, input logic [31:0] v,
                        output int n_done, output int n_busy);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        value = v;
        @(negedge clk);
        start  = 1'b0;
        n_done = 1;
        n_busy = busy ? 1 : 0;
        while (!done && n_done < 100) begin
            @(negedge clk);
            n_done++;
            if (busy) n_busy++;
        end
        if (!done) begin
            failures++;
            $display("FAIL done_timeout value=%h", v);
        end
    endtask

    int nd;
    int nb;
    int pulses;
    bit rn;
    logic [39:0] rb;
    logic [9:0]  rm;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        value = '0;

        ref_conv(1'b0, 32'd1234567890, rn, rb, rm);
        checks++;
        if (rb !== 40'h1234567890 || rn !== 1'b0 || rm !== 10'h3FF) begin
            failures++;
            $display("FAIL model_pin_a got %h %b %b", rb, rn, rm);
        end
        ref_conv(1'b1, 32'hFFFFFFD6, rn, rb, rm);
        checks++;
        if (rb !== 40'h42 || rn !== 1'b1 || rm !== 10'h003) begin
            failures++;
            $display("FAIL model_pin_b got %h %b %b", rb, rn, rm);
        end

        @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        check_lit("reset_state", 40'h0, 1'b0, 10'h001);
        check_int("reset_busy", int'(busy), 0);
        rst = 1'b0;

        conv(1'b0, 32'd0, nd, nb);
        check_lit("zero", 40'h0, 1'b0, 10'h001);
        check_int("zero_latency", nd, 34);

        conv(1'b0, 32'd1234567890, nd, nb);
        check_lit("digits_1_to_0", 40'h1234567890, 1'b0, 10'h3FF);
        check_int("busy_cycles", nb, 33);

        conv(1'b0, 32'hFFFFFFFF, nd, nb);
        check_lit("max_unsigned", 40'h4294967295, 1'b0, 10'h3FF);
        conv(1'b1, 32'hFFFFFFFF, nd, nb);
        check_lit("minus_one", 40'h1, 1'b1, 10'h001);
        conv(1'b1, 32'h80000000, nd, nb);
        check_lit("most_negative", 40'h2147483648, 1'b1, 10'h3FF);
        conv(1'b1, 32'hFFFFFFD6, nd, nb);
        check_lit("minus_42", 40'h42, 1'b1, 10'h003);
        conv(1'b1, 32'd0, nd, nb);
        check_lit("signed_zero", 40'h0, 1'b0, 10'h001);

        // Start pulse mid-conversion is dropped; start in the done cycle is taken.
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        value = 32'd305;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        value = 32'd777;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        while (!done && nd < 100) begin
            @(negedge clk);
            nd++;
        end
        check_int("done_seen_305", int'(done), 1);
        check_lit("ignored_start", 40'h305, 1'b0, 10'h007);
        start = 1'b1;
        value = 32'd12345;
        @(negedge clk);
        start = 1'b0;
        nd = 1;
        while (!done && nd < 100) begin
            @(negedge clk);
            nd++;
        end
        check_int("b2b_latency", nd, 34);
        check_lit("b2b_value", 40'h12345, 1'b0, 10'h01F);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        value = 32'd999;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("abort_busy", int'(busy), 0);
        check_lit("abort_outputs", 40'h0, 1'b0, 10'h001);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_int("abort_no_done", pulses, 0);
        conv(1'b0, 32'd7, nd, nb);
        check_lit("after_abort", 40'h7, 1'b0, 10'h001);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rv;
            rv = $urandom;
            case (i % 4)
                0: rv = rv & 32'h0000FFFF;
                1: rv = rv & 32'h000003FF;
                default: ;
            endcase
            conv(1'($urandom_range(0, 1)), rv, nd, nb);
            check_int("rand_latency", nd, 34);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (iterative double-dabble) that sits directly upstream of the per-digit seven-segment decoders.
- Converts a 32-bit register value from the CPU's display I/O path into decimal digits, each presented as a 4-bit nibble.
- Also provides a sign flag and a leading-zero mask, so the display can show signed decimal without leading zeros.
- Uses a start/busy/done handshake; outputs are held until the next conversion completes.

Parameters:
- WIDTH, 32, binary input width in bits (legal range 4..32).
- DIGITS, 10, number of BCD digits produced; must be >= ceil(WIDTH*log10(2)) (10 for 32).

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a conversion; sampled only in IDLE.
- i_signed  input  1  1 = treat i_value as two's complement; sampled with i_start.
- i_value  input  WIDTH  binary value; sampled with i_start.
- o_busy  output  1  high while a conversion is in progress (state != IDLE).
- o_done  output  1  one-cycle pulse when o_bcd, o_neg and o_nz_mask update.
- o_bcd  output  4*DIGITS  BCD result; digit 0 (units) in bits [3:0].
- o_neg  output  1  result is negative (signed mode, input MSB = 1).
- o_nz_mask  output  DIGITS  bit d = 1 if digit d must be displayed; blanks leading zeros, bit 0 is always 1.

Behaviour:
- Clock and reset (already decided): one clock, i_clk; reset is synchronous and active-high, i_reset.
- Reset values: state = IDLE, o_busy = 0, o_done = 0, o_bcd = 0, o_neg = 0, o_nz_mask = 1 (units digit only), iteration counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - At an edge with i_start = 1, capture the magnitude into the shift register: |i_value| if i_signed and i_value[WIDTH-1] = 1, else i_value.
  - Capture the sign into a neg register.
  - Clear the BCD accumulator, set counter = WIDTH, go to SHIFT.
- SHIFT: each edge performs one double-dabble iteration:
  - every accumulator digit >= 5 gets +3;
  - then {acc, shreg} shifts left by 1;
  - counter decrements;
  - when counter reaches 1 at that edge, go to DONE.
- DONE: at its edge, register the accumulator to o_bcd, neg to o_neg, and the computed mask to o_nz_mask; set o_done = 1; return to IDLE.
- o_done is high for exactly one cycle and is cleared at the next edge.
- Latency: start sampled at edge 0; outputs and o_done valid after edge WIDTH+1 (edge 33 for the default).
- o_busy is high from edge 0 until edge WIDTH+1; back-to-back throughput is WIDTH+2 cycles.
- i_start while o_busy = 1 is ignored. No queuing; the request is not remembered.
- i_start asserted in the same cycle o_done is high is accepted (state is IDLE).
- Outputs hold their last result between conversions; they change only at the DONE edge or on reset.
- Magnitude is computed in WIDTH bits unsigned: signed -2^(WIDTH-1) gives magnitude 2^(WIDTH-1) with no overflow.
- Value 0: o_bcd = 0, o_neg = 0, o_nz_mask = 1; signed 0 never reports negative.
- Mask rule: bit d = 1 if any digit at index >= d is nonzero, OR d = 0.
- Reset mid-conversion: abort on that edge, return to reset values, no o_done pulse.
- No digit may exceed 9 at any time; the accumulator never overflows for legal parameters.

Decomposition:
- Shared display package holds:
  - the FSM state enum (IDLE/SHIFT/DONE);
  - a constant BCD_DIGIT_W = 4;
  - a function computing the minimum DIGITS from WIDTH, used by an elaboration-time parameter check.
- One natural sub-module, bcd_add3: 4-bit combinational correction (+3 if >= 5), instantiated DIGITS times.
- Each o_bcd nibble feeds one seven-segment decoder instance. The top level gates each decoder with o_nz_mask and o_neg (minus sign).

Test Plan:
1. Reset, then i_start with i_value = 32'd0 and i_signed = 0 -> o_done at edge 33; o_bcd = 0; o_nz_mask = 10'b0000000001; o_neg = 0.
2. i_value = 32'd1234567890, unsigned -> o_bcd digits 1,2,3,4,5,6,7,8,9,0 (MSD first); o_nz_mask = all 1s; o_busy high for exactly 33 cycles.
3. i_value = 32'hFFFFFFFF: unsigned -> 4294967295, mask all 1s; signed -> o_bcd = 1, o_neg = 1, mask = 10'b1.
4. i_value = 32'h80000000, signed -> o_bcd = 2147483648, o_neg = 1; i_value = 32'd-42 signed -> o_bcd = 42, mask = 10'b0000000011.
5. i_start pulsed at edge 10 of a conversion of 305 -> ignored; single o_done; o_bcd = 305. A new start in the o_done cycle is accepted and its o_done arrives 34 cycles later.
6. i_reset asserted at edge 15 of a conversion of 999 -> next cycle o_busy = 0, o_bcd = 0, no o_done pulse. A following conversion of 7 yields o_bcd = 7, mask = 10'b1.
